ysyx_23060203_lsu: RTL and testbench

Load/store stage between EXU and WBU. It accepts one instruction per valid/ready handshake from EXU. Memory instructions run as one transaction on a simple request/response data-memory port; all other instructions pass straight through. Results go to WBU through a valid/ready handshake, with the GPR write data and all CSR/exception/ret/fence.i fields forwarded unchanged.

---
 rtl/ysyx_23060203_lsu.sv | 143 ++++++++++++++
 tb/tb_ysyx_23060203_lsu.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060203_lsu.sv
`default_nettype none
// ============================================================================
// Module  : ysyx_23060203_lsu
// Brief   : Load/store stage between EXU and WBU; one memory transaction per
//           memory instruction, plain passthrough for everything else.
// Revision: 1.0
// ============================================================================
module ysyx_23060203_lsu #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_pc,
    input  logic [4:0]        in_gpr_waddr,
    input  logic [31:0]       in_alu_res,
    input  logic              in_mem_ren,
    input  logic              in_mem_wen,
    input  logic [2:0]        in_funct3,
    input  logic [31:0]       in_store_data,
    input  logic              in_csr_wen,
    input  logic              in_exc,
    input  logic              in_ret,
    input  logic              in_fencei,
    input  logic [11:0]       in_csr_waddr,
    input  logic [31:0]       in_csr_wdata,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wen,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        mem_wstrb,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_pc,
    output logic [4:0]        out_gpr_waddr,
    output logic [31:0]       out_gpr_wdata,
    output logic              out_csr_wen,
    output logic [11:0]       out_csr_waddr,
    output logic [31:0]       out_csr_wdata,
    output logic              out_exc,
    output logic              out_ret,
    output logic              out_fencei
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        OUT  = 2'd3
    } state_t;

    state_t            state;
    logic [31:0]       alu_q;
    logic [31:0]       store_q;
    logic [2:0]        funct3_q;
    logic              is_store;
    logic [1:0]        off;
    logic [DATA_W-1:0] shifted;
    logic [31:0]       load_data;

    assign off           = alu_q[1:0];
    assign in_ready      = (state == IDLE);
    assign mem_req_valid = (state == REQ);
    assign out_valid     = (state == OUT);
    assign mem_addr      = alu_q[ADDR_W-1:0];
    assign mem_wen       = is_store;
    assign mem_wdata     = store_q << {off, 3'b000};

    always_comb begin
        case (funct3_q)
            3'b000:  mem_wstrb = 4'b0001 << off;
            3'b001:  mem_wstrb = 4'b0011 << off;
            default: mem_wstrb = 4'b1111;
        endcase
    end

    // Lane-align the raw word first so every size extracts from bit 0.
    always_comb begin
        shifted = mem_rdata >> {off, 3'b000};
        case (funct3_q)
            3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  load_data = {24'd0, shifted[7:0]};
            3'b101:  load_data = {16'd0, shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        out_pc        <= in_pc;
                        out_gpr_waddr <= in_gpr_waddr;
                        out_csr_wen   <= in_csr_wen;
                        out_csr_waddr <= in_csr_waddr;
                        out_csr_wdata <= in_csr_wdata;
                        out_exc       <= in_exc;
                        out_ret       <= in_ret;
                        out_fencei    <= in_fencei;
                        alu_q         <= in_alu_res;
                        store_q       <= in_store_data;
                        funct3_q      <= in_funct3;
                        is_store      <= in_mem_wen;
                        if (in_mem_ren || in_mem_wen) begin
                            state <= REQ;
                        end else begin
                            out_gpr_wdata <= in_alu_res;
                            state         <= OUT;
                        end
                    end
                end
                REQ: begin
                    if (mem_req_ready) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem_resp_valid) begin
                        out_gpr_wdata <= is_store ? 32'd0 : load_data;
                        state         <= OUT;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ysyx_23060203_lsu.sv
`default_nettype none
// ============================================================================
// Module  : tb_ysyx_23060203_lsu
// Brief   : Directed and randomized bench for the LSU with a byte-lane model.
// Revision: 1.0
// ============================================================================
module tb_ysyx_23060203_lsu;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid, in_ready;
    logic [31:0] in_pc, in_alu_res, in_store_data, in_csr_wdata;
    logic [4:0]  in_gpr_waddr;
    logic        in_mem_ren, in_mem_wen, in_csr_wen, in_exc, in_ret, in_fencei;
    logic [2:0]  in_funct3;
    logic [11:0] in_csr_waddr;
    logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;
    logic        out_valid, out_ready;
    logic [31:0] out_pc, out_gpr_wdata, out_csr_wdata;
    logic [4:0]  out_gpr_waddr;
    logic        out_csr_wen, out_exc, out_ret, out_fencei;
    logic [11:0] out_csr_waddr;

    always #5 clock = ~clock;

    ysyx_23060203_lsu dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
        .in_gpr_waddr(in_gpr_waddr), .in_alu_res(in_alu_res),
        .in_mem_ren(in_mem_ren), .in_mem_wen(in_mem_wen), .in_funct3(in_funct3),
        .in_store_data(in_store_data), .in_csr_wen(in_csr_wen), .in_exc(in_exc),
        .in_ret(in_ret), .in_fencei(in_fencei), .in_csr_waddr(in_csr_waddr),
        .in_csr_wdata(in_csr_wdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_gpr_waddr(out_gpr_waddr), .out_gpr_wdata(out_gpr_wdata),
        .out_csr_wen(out_csr_wen), .out_csr_waddr(out_csr_waddr),
        .out_csr_wdata(out_csr_wdata), .out_exc(out_exc), .out_ret(out_ret),
        .out_fencei(out_fencei)
    );

    int tests = 0;
    int fails = 0;

    logic [31:0] g_pc, g_alu, g_sd, g_rdata, g_csr_wdata;
    logic [4:0]  g_wa;
    logic [2:0]  g_f3;
    logic        g_ren, g_wen, g_csr_wen, g_exc, g_ret, g_fencei;
    logic [11:0] g_csr_waddr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic longint pow2(input int n);
        return longint'(1) << n;
    endfunction

    // Load value: pick the addressed bytes out of the word, then extend.
    function automatic logic [31:0] exp_load(input logic [2:0] f3, input int off, input logic [31:0] rd);
        longint s, v;
        int size;
        s    = longint'({32'd0, rd}) / pow2(8 * off);
        size = (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 4;
        v    = s % pow2(8 * size);
        if ((f3 == 3'd0 || f3 == 3'd1) && v >= pow2(8 * size - 1))
            v = v - pow2(8 * size);
        return v[31:0];
    endfunction

    function automatic int store_size(input logic [2:0] f3);
        return (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
    endfunction

    function automatic logic [3:0] exp_strb(input logic [2:0] f3, input int off);
        logic [3:0] s;
        int size;
        size = store_size(f3);
        s = 4'd0;
        for (int i = 0; i < 4; i++)
            if (size == 4 || (i >= off && i < off + size)) s[i] = 1'b1;
        return s;
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [31:0] sd, input int off);
        longint v;
        v = (longint'({32'd0, sd}) * pow2(8 * off)) % pow2(32);
        return v[31:0];
    endfunction

    task automatic run(input int req_stall, input int resp_dly, input int out_stall);
        int off;
        logic [31:0] exp_wd;
        off    = int'(g_alu[1:0]);
        exp_wd = g_wen ? 32'd0 : g_ren ? exp_load(g_f3, off, g_rdata) : g_alu;
        chk("in_ready_idle", {31'd0, in_ready}, 32'd1);
        in_pc = g_pc; in_alu_res = g_alu; in_store_data = g_sd; in_gpr_waddr = g_wa;
        in_funct3 = g_f3; in_mem_ren = g_ren; in_mem_wen = g_wen;
        in_csr_wen = g_csr_wen; in_exc = g_exc; in_ret = g_ret; in_fencei = g_fencei;
        in_csr_waddr = g_csr_waddr; in_csr_wdata = g_csr_wdata;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        in_pc = $urandom(); in_alu_res = $urandom(); in_store_data = $urandom();
        in_gpr_waddr = 5'($urandom()); in_funct3 = 3'($urandom());
        in_mem_ren = 1'($urandom()); in_mem_wen = 1'($urandom());
        in_exc = 1'($urandom()); in_csr_wdata = $urandom();
        if (g_ren || g_wen) begin
            for (int i = 0; i <= req_stall; i++) begin
                mem_req_ready = (i == req_stall);
                chk("req_valid", {31'd0, mem_req_valid}, 32'd1);
                chk("req_addr", mem_addr, g_alu);
                chk("req_wen", {31'd0, mem_wen}, {31'd0, g_wen});
                chk("req_in_ready", {31'd0, in_ready}, 32'd0);
                chk("req_out_valid", {31'd0, out_valid}, 32'd0);
                if (g_wen) begin
                    chk("req_wstrb", {28'd0, mem_wstrb}, {28'd0, exp_strb(g_f3, off)});
                    chk("req_wdata", mem_wdata, exp_wdata(g_sd, off));
                end
                tick();
            end
            mem_req_ready = 1'b0;
            for (int i = 0; i < resp_dly; i++) begin
                chk("wait_req_valid", {31'd0, mem_req_valid}, 32'd0);
                chk("wait_out_valid", {31'd0, out_valid}, 32'd0);
                tick();
            end
            mem_resp_valid = 1'b1;
            mem_rdata      = g_rdata;
            tick();
            mem_resp_valid = 1'b0;
        end
        for (int i = 0; i <= out_stall; i++) begin
            out_ready      = (i == out_stall);
            mem_resp_valid = (i == 0);
            mem_rdata      = $urandom();
            chk("out_valid", {31'd0, out_valid}, 32'd1);
            chk("out_in_ready", {31'd0, in_ready}, 32'd0);
            chk("out_req_valid", {31'd0, mem_req_valid}, 32'd0);
            chk("out_pc", out_pc, g_pc);
            chk("out_gpr_waddr", {27'd0, out_gpr_waddr}, {27'd0, g_wa});
            chk("out_gpr_wdata", out_gpr_wdata, exp_wd);
            chk("out_csr", {16'd0, out_csr_wen, out_exc, out_ret, out_fencei, out_csr_waddr},
                {16'd0, g_csr_wen, g_exc, g_ret, g_fencei, g_csr_waddr});
            chk("out_csr_wdata", out_csr_wdata, g_csr_wdata);
            tick();
        end
        out_ready = 1'b0;
        mem_resp_valid = 1'b0;
        chk("back_in_ready", {31'd0, in_ready}, 32'd1);
        chk("back_out_valid", {31'd0, out_valid}, 32'd0);
    endtask

    task automatic set_instr(input logic [31:0] alu, input logic [4:0] wa, input logic [2:0] f3,
                             input logic ren, input logic wen, input logic [31:0] sd,
                             input logic [31:0] rdata);
        g_pc = $urandom() & 32'hFFFF_FFFC; g_alu = alu; g_wa = wa; g_f3 = f3;
        g_ren = ren; g_wen = wen; g_sd = sd; g_rdata = rdata;
        g_csr_wen = 1'b0; g_exc = 1'b0; g_ret = 1'b0; g_fencei = 1'b0;
        g_csr_waddr = 12'h000; g_csr_wdata = 32'h0;
    endtask

    initial begin
        logic [2:0] codes [7];
        int op, size, off;
        codes = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6};
        reset = 1'b1; in_valid = 1'b0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
        mem_rdata = 32'h0; out_ready = 1'b0;
        in_pc = 0; in_alu_res = 0; in_store_data = 0; in_gpr_waddr = 0; in_funct3 = 0;
        in_mem_ren = 0; in_mem_wen = 0; in_csr_wen = 0; in_exc = 0; in_ret = 0;
        in_fencei = 0; in_csr_waddr = 0; in_csr_wdata = 0;
        tick(); tick();
        reset = 1'b0;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_req_valid", {31'd0, mem_req_valid}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);

        mem_resp_valid = 1'b1;
        tick();
        mem_resp_valid = 1'b0;
        chk("idle_resp_ignored", {30'd0, in_ready, out_valid}, 32'd2);

        set_instr(32'h1234_5678, 5'd5, 3'd0, 1'b0, 1'b0, 32'h0, 32'h0);
        run(0, 0, 0);
        set_instr(32'h8000_0003, 5'd7, 3'd0, 1'b1, 1'b0, 32'h0, 32'h80FF_FF7F);
        run(0, 1, 0);
        set_instr(32'h8000_0003, 5'd8, 3'd4, 1'b1, 1'b0, 32'h0, 32'h80FF_FF7F);
        run(1, 0, 0);
        set_instr(32'h8000_0002, 5'd0, 3'd1, 1'b0, 1'b1, 32'hAAAA_BEEF, 32'h0);
        run(0, 0, 0);
        set_instr(32'h8000_0010, 5'd9, 3'd2, 1'b1, 1'b0, 32'h0, 32'hCAFE_F00D);
        run(3, 2, 2);
        set_instr(32'h8000_0001, 5'd0, 3'd0, 1'b1, 1'b1, 32'h1234_56A5, 32'hFFFF_FFFF);
        run(0, 0, 1);
        set_instr(32'h0000_0042, 5'd3, 3'd0, 1'b0, 1'b0, 32'h0, 32'h0);
        g_exc = 1'b1; g_ret = 1'b1; g_csr_waddr = 12'h180; g_csr_wdata = 32'hDEAD_0000;
        run(0, 0, 1);

        // Reset while waiting for a load response; the late response must be dropped.
        set_instr(32'h8000_0004, 5'd4, 3'd2, 1'b1, 1'b0, 32'h0, 32'h0);
        in_alu_res = g_alu; in_mem_ren = 1'b1; in_mem_wen = 1'b0; in_funct3 = g_f3;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0; mem_req_ready = 1'b1;
        chk("rstmid_req_valid", {31'd0, mem_req_valid}, 32'd1);
        tick();
        mem_req_ready = 1'b0; reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rstmid_in_ready", {31'd0, in_ready}, 32'd1);
        mem_resp_valid = 1'b1; mem_rdata = 32'h5555_AAAA;
        tick();
        mem_resp_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("late_out_valid", {31'd0, out_valid}, 32'd0);
            chk("late_in_ready", {31'd0, in_ready}, 32'd1);
            chk("late_req_valid", {31'd0, mem_req_valid}, 32'd0);
            tick();
        end

        for (int n = 0; n < 60; n++) begin
            op = int'($urandom_range(0, 3));
            set_instr($urandom(), 5'($urandom()), codes[$urandom_range(0, 6)],
                      (op == 1 || op == 3), (op >= 2), $urandom(), $urandom());
            size = g_wen ? store_size(g_f3)
                 : (g_f3 == 3'd0 || g_f3 == 3'd4) ? 1 : (g_f3 == 3'd1 || g_f3 == 3'd5) ? 2 : 4;
            off  = (size == 1) ? int'($urandom_range(0, 3)) : (size == 2) ? 2 * int'($urandom_range(0, 1)) : 0;
            g_alu[1:0] = 2'(off);
            if (g_wen) g_wa = 5'd0;
            g_csr_wen = 1'($urandom()); g_exc = 1'($urandom()); g_ret = 1'($urandom());
            g_fencei = 1'($urandom()); g_csr_waddr = 12'($urandom()); g_csr_wdata = $urandom();
            run(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
